// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle core: opcodes, functs, ALU ops, FSM states.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
        alu_op_e op;
        unique case (funct)
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic funct_valid(input logic [5:0] funct);
        return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

endpackage

// File: rtl/mc_reg_file.sv
// NREGS x XLEN register file: two combinational read ports, one write port, R0 hardwired to 0.
module mc_reg_file
    import cpu_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned NREGS = 32,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   raddr_a_i,
    input  logic [AW-1:0]   raddr_b_i,
    output logic [XLEN-1:0] rdata_a_o,
    output logic [XLEN-1:0] rdata_b_o,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];

    // Next register contents: single write, writes to R0 dropped
    always_comb begin
        rf_d = rf_q;
        if (we_i && (waddr_i != '0)) begin
            rf_d[waddr_i] = wdata_i;
        end
    end

    // Register storage with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : rf_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : rf_q[raddr_b_i];

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: control FSM and datapath; register file in mc_reg_file.
module multi_cycle_cpu
    import cpu_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_ready_i,
    output logic            retire_o,
    output logic            halt_o,
    output logic [XLEN-1:0] pc_o
);

    localparam int unsigned AW = $clog2(NREGS);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] res_q, res_d;

    logic [5:0]      opcode, funct;
    logic [4:0]      rs_f, rt_f, rd_f;
    logic [XLEN-1:0] imm_sext, alu_y, rd_a, rd_b;
    logic            legal, rf_we;
    logic [AW-1:0]   rf_waddr;
    logic            unused_shamt;

    assign opcode       = ir_q[31:26];
    assign rs_f         = ir_q[25:21];
    assign rt_f         = ir_q[20:16];
    assign rd_f         = ir_q[15:11];
    assign funct        = ir_q[5:0];
    assign imm_sext     = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
    assign unused_shamt = ^ir_q[10:6];
    assign rf_waddr     = (opcode == OP_RTYPE) ? rd_f[AW-1:0] : rt_f[AW-1:0];

    mc_reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .raddr_a_i (rs_f[AW-1:0]),
        .raddr_b_i (rt_f[AW-1:0]),
        .rdata_a_o (rd_a),
        .rdata_b_o (rd_b),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (res_q)
    );

    // Opcode/funct legality check used in DECODE
    always_comb begin
        unique case (opcode)
            OP_RTYPE:                                 legal = funct_valid(funct);
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal = 1'b1;
            default:                                  legal = 1'b0;
        endcase
    end

    // R-type ALU, wraps modulo 2^XLEN
    always_comb begin
        unique case (funct_to_alu(funct))
            ALU_SUB: alu_y = a_q - b_q;
            ALU_AND: alu_y = a_q & b_q;
            ALU_OR:  alu_y = a_q | b_q;
            ALU_SLT: alu_y = XLEN'($signed(a_q) < $signed(b_q));
            default: alu_y = a_q + b_q;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH:  if (mem_ready_i) state_d = ST_DECODE;
            ST_DECODE: state_d = legal ? ST_EXEC : ST_HALT;
            ST_EXEC: begin
                unique case (opcode)
                    OP_LW, OP_SW:          state_d = ST_MEM;
                    OP_BEQ, OP_BNE, OP_J:  state_d = ST_FETCH;
                    default:               state_d = ST_WB;
                endcase
            end
            ST_MEM:    if (mem_ready_i) state_d = (opcode == OP_SW) ? ST_FETCH : ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_HALT;
        endcase
    end

    // Datapath register updates and register-file write enable
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        a_d   = a_q;
        b_d   = b_q;
        res_d = res_q;
        rf_we = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                if (mem_ready_i) begin
                    ir_d = mem_rdata_i[31:0];
                    pc_d = pc_q + XLEN'(4);
                end
            end
            ST_DECODE: begin
                a_d = rd_a;
                b_d = rd_b;
            end
            ST_EXEC: begin
                unique case (opcode)
                    OP_RTYPE: res_d = alu_y;
                    OP_BEQ:   if (a_q == b_q) pc_d = pc_q + (imm_sext << 2);
                    OP_BNE:   if (a_q != b_q) pc_d = pc_q + (imm_sext << 2);
                    OP_J:     pc_d = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
                    default:  res_d = a_q + imm_sext;
                endcase
            end
            // res_q holds the effective address until the load data replaces it
            ST_MEM:  if (mem_ready_i && (opcode == OP_LW)) res_d = mem_rdata_i;
            ST_WB:   rf_we = 1'b1;
            default: ;
        endcase
    end

    // Moore outputs plus ready-qualified retire for stores
    always_comb begin
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = res_q;
        retire_o   = 1'b0;
        halt_o     = 1'b0;
        unique case (state_q)
            // FETCH is also the reset state; gate so no request is shown while in reset
            ST_FETCH: begin
                mem_req_o  = rst_i;
                mem_addr_o = pc_q;
            end
            ST_EXEC:  retire_o = opcode inside {OP_BEQ, OP_BNE, OP_J};
            ST_MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = (opcode == OP_SW);
                retire_o  = mem_ready_i && (opcode == OP_SW);
            end
            ST_WB:    retire_o = 1'b1;
            ST_HALT:  halt_o = 1'b1;
            default:  ;
        endcase
    end

    assign mem_wdata_o = b_q;
    assign pc_o        = pc_q;

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Self-checking bench for multi_cycle_cpu: directed scenarios plus random programs vs an ISS.
module tb_multi_cycle_cpu;

    localparam logic [31:0] HALT_W = 32'hFC00_0000;
    localparam logic [31:0] NO_ADDR = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        mem_req_o, mem_we_o, mem_ready_i, retire_o, halt_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, pc_o;

    always #5 clk = ~clk;

    multi_cycle_cpu #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_ready_i(mem_ready_i), .retire_o(retire_o), .halt_o(halt_o), .pc_o(pc_o)
    );

    int unsigned errors = 0, checks = 0;

    logic [31:0] mem [256];
    logic [31:0] iss_mem [256];
    logic [31:0] prog_a[$], prog_w[$];
    int unsigned ret_cyc[$];
    logic [31:0] pc_after[$], wr_addr[$], wr_data[$];
    logic [31:0] exp_pc[$], exp_wa[$], exp_wd[$];
    int unsigned stable_viol, halt_reqs, halt_rets, cyc, cnt, cur_wait, slow_n;
    logic [31:0] slow_addr = NO_ADDR, req_addr, req_wd;
    logic        req_we, ret_prev, rand_wait = 1'b0;

    // Memory responder and retire/PC monitor, evaluated away from the active edge
    always @(negedge clk) begin
        if (!rst_i) begin
            mem_ready_i = 1'b0; mem_rdata_i = '0; cnt = 0; cyc = 0; ret_prev = 1'b0;
        end else begin
            cyc++;
            if (ret_prev) pc_after.push_back(pc_o);
            if (mem_req_o) begin
                if (halt_o) halt_reqs++;
                if (cnt == 0) begin
                    req_addr = mem_addr_o; req_we = mem_we_o; req_wd = mem_wdata_o;
                    cur_wait = (mem_addr_o == slow_addr) ? slow_n : (rand_wait ? $urandom_range(0, 2) : 0);
                end else if (mem_addr_o !== req_addr || mem_we_o !== req_we ||
                             (req_we && mem_wdata_o !== req_wd)) begin
                    stable_viol++;
                end
                if (cnt >= cur_wait) begin
                    mem_ready_i = 1'b1;
                    mem_rdata_i = mem[mem_addr_o[9:2]];
                    if (mem_we_o) begin
                        mem[mem_addr_o[9:2]] = mem_wdata_o;
                        wr_addr.push_back(mem_addr_o);
                        wr_data.push_back(mem_wdata_o);
                    end
                    cnt = 0;
                end else begin
                    mem_ready_i = 1'b0; mem_rdata_i = $urandom; cnt++;
                end
            end else begin
                mem_ready_i = 1'b0; mem_rdata_i = $urandom; cnt = 0;
            end
            #1;
            ret_prev = retire_o;
            if (retire_o) begin
                ret_cyc.push_back(cyc);
                if (halt_o) halt_rets++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        prog_a.push_back(a); prog_w.push_back(w);
    endtask

    // Hold reset, load the program image, release just after a rising edge
    task automatic load_and_start();
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 256; i++) mem[i] = HALT_W;
        foreach (prog_a[i]) mem[prog_a[i][9:2]] = prog_w[i];
        for (int i = 0; i < 256; i++) iss_mem[i] = mem[i];
        prog_a.delete(); prog_w.delete();
        ret_cyc.delete(); pc_after.delete(); wr_addr.delete(); wr_data.delete();
        stable_viol = 0; halt_reqs = 0; halt_rets = 0;
        @(posedge clk); #1 rst_i = 1'b1;
    endtask

    task automatic run_to_halt(input int unsigned budget, input string name);
        int unsigned n = 0;
        while (!halt_o && n < budget) begin @(negedge clk); #2; n++; end
        checks++;
        if (halt_o !== 1'b1) begin
            errors++; $display("FAIL %s_halt: halt_o=%b after %0d cycles, required 1", name, halt_o, n);
        end
        repeat (10) @(negedge clk);
        #2;
    endtask

    // Instruction-level reference: executes iss_mem from PC 0 until an illegal word
    task automatic iss_run();
        logic [31:0] r [32];
        logic [31:0] pc, ir, a, b, imm, ea, res;
        exp_pc.delete(); exp_wa.delete(); exp_wd.delete();
        for (int i = 0; i < 32; i++) r[i] = '0;
        pc = '0;
        for (int step = 0; step < 2000; step++) begin
            ir = iss_mem[pc[9:2]];
            pc = pc + 4;
            a = r[ir[25:21]]; b = r[ir[20:16]];
            imm = {{16{ir[15]}}, ir[15:0]};
            case (ir[31:26])
                6'h00: begin
                    case (ir[5:0])
                        6'h20: res = a + b;
                        6'h22: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: return;
                    endcase
                    if (ir[15:11] != 0) r[ir[15:11]] = res;
                end
                6'h08: if (ir[20:16] != 0) r[ir[20:16]] = a + imm;
                6'h23: begin ea = a + imm; if (ir[20:16] != 0) r[ir[20:16]] = iss_mem[ea[9:2]]; end
                6'h2B: begin ea = a + imm; iss_mem[ea[9:2]] = b; exp_wa.push_back(ea); exp_wd.push_back(b); end
                6'h04: if (a == b) pc = pc + (imm << 2);
                6'h05: if (a != b) pc = pc + (imm << 2);
                6'h02: pc = {pc[31:28], ir[25:0], 2'b00};
                default: return;
            endcase
            exp_pc.push_back(pc);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
        checks++; if (retire_o !== 1'b0) begin errors++; $display("FAIL reset_retire: got %b want 0", retire_o); end
        checks++; if (halt_o !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", halt_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc_o); end
    endtask

    task automatic test_zero_wait();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'd7));
        put(32'h08, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        put(32'h0C, enc_i(6'h2B, 5'd0, 5'd3, 16'h80));
        load_and_start();
        #1;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            errors++; $display("FAIL first_fetch: req=%b addr=%h want req=1 addr=0", mem_req_o, mem_addr_o); end
        run_to_halt(100, "zero_wait");
        checks++; if (ret_cyc.size() != 4) begin errors++; $display("FAIL zw_retires: got %0d want 4", ret_cyc.size()); end
        checks++; if (ret_cyc[0] != 4 || ret_cyc[1] != 8 || ret_cyc[2] != 12) begin
            errors++; $display("FAIL zw_cycles: retires at %0d,%0d,%0d want 4,8,12", ret_cyc[0], ret_cyc[1], ret_cyc[2]); end
        checks++; if (wr_addr[0] !== 32'h80 || wr_data[0] !== 32'd12) begin
            errors++; $display("FAIL zw_r3: wrote %h@%h want 0000000c@00000080", wr_data[0], wr_addr[0]); end
    endtask

    task automatic test_wait_states();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'd7));
        put(32'h08, enc_r(5'd2, 5'd1, 5'd4, 6'h22));
        put(32'h0C, enc_i(6'h2B, 5'd0, 5'd4, 16'h80));
        slow_addr = 32'h08; slow_n = 3;
        load_and_start();
        run_to_halt(100, "wait");
        slow_addr = NO_ADDR;
        checks++; if (stable_viol != 0) begin errors++; $display("FAIL wait_stable: %0d changes while waiting, want 0", stable_viol); end
        checks++; if (ret_cyc[2] - ret_cyc[1] != 7) begin
            errors++; $display("FAIL wait_sub_cycles: got %0d want 7", ret_cyc[2] - ret_cyc[1]); end
        checks++; if (wr_data[0] !== 32'd2) begin errors++; $display("FAIL wait_r4: got %h want 2", wr_data[0]); end
    endtask

    task automatic test_memory();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'd7));
        put(32'h08, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        put(32'h0C, enc_i(6'h2B, 5'd0, 5'd3, 16'd8));
        put(32'h10, enc_i(6'h23, 5'd0, 5'd5, 16'd8));
        put(32'h14, enc_i(6'h2B, 5'd0, 5'd5, 16'h84));
        load_and_start();
        run_to_halt(100, "memory");
        checks++; if (wr_addr[0] !== 32'd8 || wr_data[0] !== 32'd12) begin
            errors++; $display("FAIL mem_sw: wrote %h@%h want 0000000c@00000008", wr_data[0], wr_addr[0]); end
        checks++; if (wr_addr[1] !== 32'h84 || wr_data[1] !== 32'd12) begin
            errors++; $display("FAIL mem_lw_r5: wrote %h@%h want 0000000c@00000084", wr_data[1], wr_addr[1]); end
        checks++; if (ret_cyc[3] - ret_cyc[2] != 4) begin errors++; $display("FAIL mem_sw_cycles: got %0d want 4", ret_cyc[3] - ret_cyc[2]); end
        checks++; if (ret_cyc[4] - ret_cyc[3] != 5) begin errors++; $display("FAIL mem_lw_cycles: got %0d want 5", ret_cyc[4] - ret_cyc[3]); end
    endtask

    task automatic test_branches();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd3));
        put(32'h10, enc_i(6'h04, 5'd1, 5'd1, 16'd2));
        put(32'h1C, enc_j(26'h40));
        put(32'h100, enc_i(6'h05, 5'd1, 5'd1, 16'd5));
        for (int i = 1; i < 4; i++) put(32'(i * 4), 32'h2000_0000);  // addi r0,r0,0
        load_and_start();
        run_to_halt(100, "branch");
        checks++; if (pc_after[4] !== 32'h1C) begin errors++; $display("FAIL beq_pc: got %h want 0000001c", pc_after[4]); end
        checks++; if (pc_after[5] !== 32'h100) begin errors++; $display("FAIL j_pc: got %h want 00000100", pc_after[5]); end
        checks++; if (pc_after[6] !== 32'h104) begin errors++; $display("FAIL bne_far_pc: got %h want 00000104", pc_after[6]); end
        checks++; if (ret_cyc[4] - ret_cyc[3] != 3 || ret_cyc[5] - ret_cyc[4] != 3) begin
            errors++; $display("FAIL branch_cycles: beq %0d j %0d want 3 3", ret_cyc[4] - ret_cyc[3], ret_cyc[5] - ret_cyc[4]); end
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd3));
        for (int i = 1; i < 4; i++) put(32'(i * 4), 32'h2000_0000);
        put(32'h10, enc_i(6'h05, 5'd1, 5'd1, 16'd2));
        load_and_start();
        run_to_halt(100, "bne");
        checks++; if (pc_after[4] !== 32'h14) begin errors++; $display("FAIL bne_pc: got %h want 00000014", pc_after[4]); end
    endtask

    task automatic test_corner();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF));
        put(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'd1));
        put(32'h08, enc_r(5'd1, 5'd2, 5'd6, 6'h2A));
        put(32'h0C, enc_r(5'd2, 5'd1, 5'd7, 6'h2A));
        put(32'h10, enc_i(6'h08, 5'd0, 5'd0, 16'd9));
        put(32'h14, enc_i(6'h2B, 5'd0, 5'd6, 16'h80));
        put(32'h18, enc_i(6'h2B, 5'd0, 5'd7, 16'h84));
        put(32'h1C, enc_i(6'h2B, 5'd0, 5'd0, 16'h88));
        load_and_start();
        run_to_halt(200, "corner");
        repeat (10) @(negedge clk);
        #2;
        checks++; if (wr_data[0] !== 32'd1) begin errors++; $display("FAIL slt_neg: got %h want 1", wr_data[0]); end
        checks++; if (wr_data[1] !== 32'd0) begin errors++; $display("FAIL slt_pos: got %h want 0", wr_data[1]); end
        checks++; if (wr_data[2] !== 32'd0) begin errors++; $display("FAIL r0_write: got %h want 0", wr_data[2]); end
        checks++; if (halt_reqs != 0) begin errors++; $display("FAIL halt_reqs: %0d requests after halt, want 0", halt_reqs); end
        checks++; if (ret_cyc.size() != 8 || halt_rets != 0) begin
            errors++; $display("FAIL halt_retire: retires=%0d in_halt=%0d want 8 0", ret_cyc.size(), halt_rets); end
        put(32'h00, enc_r(5'd0, 5'd0, 5'd1, 6'h21));
        load_and_start();
        run_to_halt(50, "bad_funct");
        checks++; if (ret_cyc.size() != 0) begin errors++; $display("FAIL bad_funct_retire: got %0d want 0", ret_cyc.size()); end
    endtask

    task automatic test_reset_mid();
        int unsigned n = 0;
        put(32'h00, enc_i(6'h08, 5'd0, 5'd3, 16'd12));
        put(32'h04, enc_i(6'h2B, 5'd0, 5'd3, 16'd8));
        slow_addr = 32'h08; slow_n = 30;
        load_and_start();
        while (!(mem_req_o && mem_we_o) && n < 40) begin @(negedge clk); #2; n++; end
        checks++; if (!(mem_req_o && mem_we_o)) begin errors++; $display("FAIL rst_sw_seen: no store request in %0d cycles", n); end
        repeat (2) @(negedge clk);
        #3 rst_i = 1'b0;
        #1;
        slow_addr = NO_ADDR;
        checks++; if (mem_req_o !== 1'b0 || retire_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs: req=%b retire=%b want 0 0", mem_req_o, retire_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_mid_pc: got %h want 0", pc_o); end
        checks++; if (wr_addr.size() != 0 || mem[2] !== HALT_W) begin
            errors++; $display("FAIL rst_mid_nowrite: writes=%0d mem8=%h want 0 %h", wr_addr.size(), mem[2], HALT_W); end
        put(32'h00, enc_i(6'h2B, 5'd0, 5'd3, 16'h80));
        load_and_start();
        #1;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            errors++; $display("FAIL rst_refetch: req=%b addr=%h want 1 0", mem_req_o, mem_addr_o); end
        run_to_halt(50, "rst_restart");
        checks++; if (wr_data[0] !== 32'd0) begin errors++; $display("FAIL rst_regs_clear: r3=%h want 0", wr_data[0]); end
    endtask

    task automatic test_random();
        logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        logic [4:0] rs, rt, rd;
        logic [15:0] dimm;
        rand_wait = 1'b1;
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 24; i++) begin
                rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
                dimm = 16'(32'h200 + 4 * $urandom_range(0, 15));
                case ($urandom_range(0, 9))
                    0, 1, 2: put(32'(i * 4), enc_r(rs, rt, rd, fns[$urandom_range(0, 4)]));
                    3, 4:    put(32'(i * 4), enc_i(6'h08, rs, rt, 16'($urandom)));
                    5:       put(32'(i * 4), enc_i(6'h2B, 5'd0, rt, dimm));
                    6:       put(32'(i * 4), enc_i(6'h23, 5'd0, rt, dimm));
                    7:       put(32'(i * 4), enc_i(6'h04, rs, rt, 16'($urandom_range(0, 3))));
                    8:       put(32'(i * 4), enc_i(6'h05, rs, rt, 16'($urandom_range(0, 3))));
                    default: put(32'(i * 4), enc_j(26'(i + 1 + $urandom_range(0, 3))));
                endcase
            end
            load_and_start();
            iss_run();
            run_to_halt(600, "random");
            checks++; if (pc_after.size() != exp_pc.size() || ret_cyc.size() != exp_pc.size()) begin
                errors++; $display("FAIL rnd%0d_retires: pcs=%0d retires=%0d want %0d", p, pc_after.size(), ret_cyc.size(), exp_pc.size()); end
            foreach (exp_pc[i]) begin
                checks++; if (pc_after[i] !== exp_pc[i]) begin
                    errors++; $display("FAIL rnd%0d_pc[%0d]: got %h want %h", p, i, pc_after[i], exp_pc[i]); end
            end
            checks++; if (wr_addr.size() != exp_wa.size()) begin
                errors++; $display("FAIL rnd%0d_nwrites: got %0d want %0d", p, wr_addr.size(), exp_wa.size()); end
            foreach (exp_wa[i]) begin
                checks++; if (wr_addr[i] !== exp_wa[i] || wr_data[i] !== exp_wd[i]) begin
                    errors++; $display("FAIL rnd%0d_wr[%0d]: got %h@%h want %h@%h", p, i, wr_data[i], wr_addr[i], exp_wd[i], exp_wa[i]); end
            end
            checks++; if (stable_viol != 0) begin errors++; $display("FAIL rnd%0d_stable: %0d changes, want 0", p, stable_viol); end
        end
        rand_wait = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_memory();
        test_branches();
        test_corner();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_cycle_cpu.md
MULTI_CYCLE_CPU -- requirements
Module: multi_cycle_cpu

Interface
REQ-001 Parameters SHALL be as follows, one per line:
- XLEN, default 32, datapath and address width; must be 32 or 64.
- NREGS, default 32, register count; a power of two, at most 32.
- RESET_PC, default 0, PC value loaded at reset.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk_i, in, 1, the single clock.
- rst_i, in, 1, asynchronous active-low reset.
- mem_req_o, out, 1, memory request valid.
- mem_we_o, out, 1, 1 = write, 0 = read.
- mem_addr_o, out, XLEN, byte address.
- mem_wdata_o, out, XLEN, store data.
- mem_rdata_i, in, XLEN, read data; valid when mem_ready_i=1.
- mem_ready_i, in, 1, memory completes the request this cycle.
- retire_o, out, 1, one-cycle pulse per completed instruction.
- halt_o, out, 1, core halted.
- pc_o, out, XLEN, current PC.

Function
REQ-003 The control FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-004 FETCH SHALL behave as follows:
- Drive mem_req_o=1, mem_we_o=0, mem_addr_o=PC, and hold them stable until mem_ready_i=1.
- When ready: latch IR from mem_rdata_i[31:0], set PC<=PC+4, go to DECODE.
REQ-005 DECODE SHALL latch A<=R[rs] and B<=R[rt]; R0 SHALL always read 0; register index SHALL be the low log2(NREGS) bits of the field.
REQ-006 Supported opcodes SHALL be:
- R-type 0x00 with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
- addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02.
REQ-007 ALU arithmetic SHALL wrap modulo 2^XLEN with no overflow trap; slt SHALL compare signed; immediates SHALL be sign-extended to XLEN.
REQ-008 Branches SHALL be taken in EXEC with target = PC + (sext(imm)<<2), where PC already holds PC+4; the instruction SHALL then retire and return to FETCH.
REQ-009 j SHALL set PC <= {PC[XLEN-1:28], imm26, 2'b00} in EXEC, then retire and return to FETCH.
REQ-010 lw and sw SHALL use EXEC for address = A + sext(imm), then MEM:
- mem_req_o=1, mem_we_o=1 for sw, mem_wdata_o=B, held until mem_ready_i=1.
- sw retires on ready; lw latches the read data and goes to WB.
REQ-011 WB SHALL write rd (R-type), or rt (addi, lw); writes to R0 SHALL be discarded.
REQ-012 Cycles per instruction with mem_ready_i tied high SHALL be: branch and j 3; R-type, addi and sw 4; lw 5; each wait cycle adds 1.
REQ-013 retire_o SHALL pulse in the final cycle of each instruction; pc_o SHALL equal the PC register.
REQ-014 An unknown opcode or funct SHALL go to HALT:
- halt_o=1, mem_req_o=0, no register writes, no retire_o pulse.
- HALT is left only by reset.
REQ-015 mem_req_o SHALL be 0 in DECODE, EXEC, WB and HALT, and SHALL deassert the cycle after ready is accepted.

Reset
REQ-016 rst_i low SHALL asynchronously:
- set FSM=FETCH, PC=RESET_PC, IR=0, A=B=0, all registers 0;
- drive mem_req_o=0, retire_o=0, halt_o=0.
REQ-017 Reset asserted mid-request SHALL abandon the transaction, with no partial write or retire.
REQ-018 Fetch SHALL begin in the first clock edge after rst_i rises.

Structure
REQ-019 Opcode and funct constants, ALU-op encodings and the state encoding SHALL live in the shared package cpu_pkg.
REQ-020 The register file SHALL be one sub-module, mc_reg_file (NREGS x XLEN, 2 read ports, 1 write port); the FSM and datapath stay in multi_cycle_cpu.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Zero-wait: addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 -> r3=12, 12 cycles total, 3 retire pulses.
- Wait states: ready delayed 3 cycles on fetch of sub r4,r2,r1 -> request held stable, r4=2, 7 cycles.
- Memory: sw r3,8(r0) then lw r5,8(r0) -> write addr 8, data 12; r5=12; lw takes 5 cycles.
- Branches: beq r1,r1,+2 at PC 0x10 -> PC=0x1C; bne r1,r1 -> PC=0x14; j 0x40 -> PC=0x100.
- Corner cases: slt with r1=-1, r2=1 -> 1; addi r0,r0,9 -> r0 stays 0; opcode 0x3F -> halt_o=1, no further requests.
- Reset: rst_i low during a pending sw -> no write, pc_o=RESET_PC, fetch restarts at RESET_PC.
